jk_excitation_driver: RTL and testbench
=======================================

// Module: jk_excitation_driver
// PURPOSE
//  Drive side of a bank of JK flip-flops: accepts target state words over a valid/ready handshake and emits
//  one-cycle J/K excitation pulses that move each flop from its current state to the target.
//  Tracks a model of flop state, checks flop feedback after a fixed settle latency, and counts mismatches.
//  Sits between a control/sequencer and a WIDTH-bit JK register bank clocked by the same clk.
// PARAMETERS
//  WIDTH      4  number of JK bits driven
//  FB_LAT     1  cycles from first J/K-high cycle to the cycle where q_fb shows the result (>=1)
//  ERR_CNT_W  8  width of saturating mismatch counter
// PORTS
//  clk        input   1          system clock, rising edge
//  rst        input   1          synchronous reset, active-low (rst==0 resets on the clk edge)
//  in_valid   input   1          target word valid
//  in_ready   output  1          block accepts target this cycle (==state IDLE)
//  in_target  input   WIDTH      desired flop state
//  j          output  WIDTH      J excitation, registered
//  k          output  WIDTH      K excitation, registered
//  q_fb       input   WIDTH      flop outputs fed back
//  done       output  1          one-cycle pulse: transfer checked
//  mismatch   output  1          one-cycle pulse, with check: q_fb != expected
//  err_count  output  ERR_CNT_W  saturating count of mismatch pulses
// BEHAVIOUR
//  Reset (rst==0 at an edge): j=0, k=0, in_ready=0, done=0, mismatch=0, err_count=0, q_model=0,
//   state=CLR. Reset mid-transfer aborts it; no done; re-enters CLR.
//  States: CLR -> WAIT; IDLE -> DRIVE on accept; DRIVE -> WAIT; WAIT -> IDLE after FB_LAT cycles.
//  CLR (1 cycle): register j=0, k=all-ones, expected=0 (forces known state); -> WAIT.
//  IDLE: in_ready=1. Accept when in_valid&&in_ready at cycle t: expected<=in_target; j/k registered
//   per bit from q_model -> target: 0->0 j0k0; 0->1 j1k0; 1->0 j0k1; 1->1 j0k0 (no toggle code, no X).
//  DRIVE = cycle t+1: j/k high exactly this cycle; j/k return to 0 at the next edge.
//  WAIT: cycles t+2..t+1+FB_LAT; j=k=0; internal counter FB_LAT-1 down to 0.
//  Check: q_fb sampled at the edge ending cycle t+1+FB_LAT. In cycle t+2+FB_LAT: state=IDLE;
//   done=1; mismatch=(q_fb!=expected); q_model<=q_fb (resync to real flops, not to target).
//  Latency accept->done = FB_LAT+2 cycles (FB_LAT=1: accept cycle 0, j/k cycle 1, done cycle 3).
//  Back-to-back: in_ready is 1 in the done cycle; a new accept there is legal.
//  in_valid while in_ready=0 is ignored; upstream holds in_target until accepted.
//  CLR check: mismatch and err_count update as normal, but done is NOT pulsed.
//  err_count: +1 per mismatch pulse, saturates at 2**ERR_CNT_W-1, cleared only by reset.
//  All outputs registered; no combinational path from in_valid/q_fb to any output.
// STRUCTURE
//  Package jk_drv_pkg: state enum {CLR,IDLE,DRIVE,WAIT}; 2-bit excitation encodings; function
//   jk_excite(q,target) returning {j,k} per bit.
//  Sub-module jk_excite_enc: per-bit combinational mapper (q_model,target) -> (j,k), generated WIDTH times.
//  Top holds FSM, FB_LAT counter, expected/q_model regs, err counter.
// TESTING (bench closes the loop with a behavioural per-bit JK flip-flop model, FB_LAT=1, WIDTH=4)
//  Reset release -> cycle 1 k=4'hF j=0, no done, mismatch=0, err_count=0, in_ready=1 at cycle 3.
//  From q=0000, target 4'b1010 accepted cycle 0 -> j=1010 k=0000 in cycle 1 only, done cycle 3, q_fb=1010.
//  From q=1010, target 4'b0110 -> j=0100 k=1000; done, mismatch=0; target 1010 again -> j=1000 k=0100.
//  Model forced to ignore K on bit0, target 0000 from 0001 -> mismatch=1, err_count=1, q_model=0001.
//  Back-to-back: in_valid held high with 3 targets -> accepts at cycles 0,3,6; in_ready low cycles 1-2,4-5.
//  rst=0 during WAIT -> no done; j=k=0; CLR replayed; err_count saturates at 255 after 300 forced errors.

Source files
------------

// File: rtl/jk_drv_pkg.sv
// rtl/jk_drv_pkg.sv - shared types and excitation helper for the JK excitation driver
package jk_drv_pkg;

   typedef enum logic [1:0] {
      ST_CLR   = 2'd0,
      ST_IDLE  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_WAIT  = 2'd3
   } drv_state_t;

   // Excitation codes, packed as {j,k}; the toggle code 2'b11 is never produced
   localparam logic [1:0] EXC_HOLD  = 2'b00;
   localparam logic [1:0] EXC_SET   = 2'b10;
   localparam logic [1:0] EXC_RESET = 2'b01;

   // Minimal excitation that moves one flop from q to target
   function automatic logic [1:0] jk_excite(input logic q, input logic target);
      logic [1:0] code;
      case ({q, target})
         2'b01:   code = EXC_SET;
         2'b10:   code = EXC_RESET;
         default: code = EXC_HOLD;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/jk_excite_enc.sv
// rtl/jk_excite_enc.sv - per-bit mapper from (modelled state, target) to J/K excitation
module jk_excite_enc
   import jk_drv_pkg::*;
(
   input  logic q,
   input  logic target,
   output logic j,
   output logic k
);

   // Pure lookup; the top registers the result when a target is accepted
   always_comb begin
      {j, k} = jk_excite(q, target);
   end

endmodule

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - drives JK flop bank toward target words and checks feedback
module jk_excitation_driver
   import jk_drv_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int FB_LAT    = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_target,
   output logic [WIDTH-1:0]     j,
   output logic [WIDTH-1:0]     k,
   input  logic [WIDTH-1:0]     q_fb,
   output logic                 done,
   output logic                 mismatch,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int CNT_W = $clog2(FB_LAT + 1);
   // The clear path has no separate DRIVE state, so its wait runs one cycle longer
   localparam logic [CNT_W-1:0] CNT_CLR = CNT_W'(FB_LAT);
   localparam logic [CNT_W-1:0] CNT_DRV = CNT_W'(FB_LAT - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

   drv_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             from_clr_q;
   logic [WIDTH-1:0] expected_q;
   logic [WIDTH-1:0] q_model_q;
   logic [WIDTH-1:0] exc_j, exc_k;
   logic             accept;
   logic             wait_over;
   logic             fb_bad;

   assign accept    = in_valid && (state_q == ST_IDLE);
   assign wait_over = (state_q == ST_WAIT) && (cnt_q == '0);
   assign fb_bad    = (q_fb != expected_q);

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_enc
         jk_excite_enc u_enc (
            .q      (q_model_q[g]),
            .target (in_target[g]),
            .j      (exc_j[g]),
            .k      (exc_k[g])
         );
      end
   endgenerate

   // State register; reset always replays the clear sequence
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_CLR;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_CLR:   state_d = ST_WAIT;
         ST_IDLE:  state_d = accept ? ST_DRIVE : ST_IDLE;
         ST_DRIVE: state_d = ST_WAIT;
         ST_WAIT:  state_d = (cnt_q == '0) ? ST_IDLE : ST_WAIT;
         default:  state_d = ST_CLR;
      endcase
   end

   // Output decode: ready is a pure function of the state register
   always_comb begin
      in_ready = (state_q == ST_IDLE);
   end

   // Excitation, settle counter, feedback check and error counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         j          <= '0;
         k          <= '0;
         done       <= 1'b0;
         mismatch   <= 1'b0;
         err_count  <= '0;
         q_model_q  <= '0;
         expected_q <= '0;
         cnt_q      <= '0;
         from_clr_q <= 1'b0;
      end else begin
         j        <= '0;
         k        <= '0;
         done     <= 1'b0;
         mismatch <= 1'b0;
         case (state_q)
            ST_CLR: begin
               k          <= '1;
               expected_q <= '0;
               cnt_q      <= CNT_CLR;
               from_clr_q <= 1'b1;
            end
            ST_IDLE: begin
               if (accept) begin
                  j          <= exc_j;
                  k          <= exc_k;
                  expected_q <= in_target;
                  from_clr_q <= 1'b0;
               end
            end
            ST_DRIVE: begin
               cnt_q <= CNT_DRV;
            end
            ST_WAIT: begin
               if (wait_over) begin
                  done      <= !from_clr_q;
                  mismatch  <= fb_bad;
                  // Follow the real flops so the next excitation starts from truth
                  q_model_q <= q_fb;
                  if (fb_bad && (err_count != ERR_MAX))
                     err_count <= err_count + ERR_CNT_W'(1);
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - scoreboard bench closing the loop through a JK flop model
module tb_jk_excitation_driver;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_target;
   logic [3:0] j, k;
   logic [3:0] q_fb;
   logic       done, mismatch;
   logic [7:0] err_count;

   logic [3:0] flops = 4'b0110;
   logic       ign_k0 = 1'b0;
   logic [9:0] exp_q[$];
   logic [9:0] mon_e;
   int         n_cmp = 0;
   int         n_mis = 0;

   jk_excitation_driver #(.WIDTH(4), .FB_LAT(1), .ERR_CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_target (in_target),
      .j         (j),
      .k         (k),
      .q_fb      (q_fb),
      .done      (done),
      .mismatch  (mismatch),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   // Behavioural JK bank; bit0 can be made deaf to K to provoke mismatches
   function automatic logic [3:0] jk_next(input logic [3:0] q, input logic [3:0] jj,
                                          input logic [3:0] kk, input logic ign);
      logic [3:0] n;
      logic       kb;
      for (int i = 0; i < 4; i++) begin
         kb = kk[i] && !(i == 0 && ign);
         case ({jj[i], kb})
            2'b10:   n[i] = 1'b1;
            2'b01:   n[i] = 1'b0;
            2'b11:   n[i] = ~q[i];
            default: n[i] = q[i];
         endcase
      end
      return n;
   endfunction

   always @(posedge clk) flops <= jk_next(flops, j, k, ign_k0);
   assign q_fb = flops;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every done/mismatch pulse must match the oldest scoreboard entry
   always @(negedge clk) begin
      if (rst === 1'b1 && (done === 1'b1 || mismatch === 1'b1)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL unexpected_pulse: got done=%0b mismatch=%0b expected none at %0t",
                     done, mismatch, $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("done", 32'(done), 32'(mon_e[9]));
            chk("mismatch", 32'(mismatch), 32'(mon_e[8]));
            chk("err_count", 32'(err_count), 32'(mon_e[7:0]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic xfer(input logic [3:0] tgt, input logic [3:0] ej, input logic [3:0] ek,
                       input logic emm, input logic [7:0] eerr);
      chk("ready_idle", 32'(in_ready), 32'd1);
      exp_q.push_back({1'b1, emm, eerr});
      in_valid  = 1'b1;
      in_target = tgt;
      step();
      in_valid = 1'b0;
      chk("j_drive", 32'(j), 32'(ej));
      chk("k_drive", 32'(k), 32'(ek));
      chk("ready_drive", 32'(in_ready), 32'd0);
      step();
      chk("j_wait", 32'(j), 32'd0);
      chk("k_wait", 32'(k), 32'd0);
      step();
   endtask

   task automatic check_clr();
      chk("clr_j0", 32'(j), 32'd0);
      chk("clr_k0", 32'(k), 32'd0);
      chk("clr_ready0", 32'(in_ready), 32'd0);
      chk("clr_err0", 32'(err_count), 32'd0);
      step();
      chk("clr_j1", 32'(j), 32'd0);
      chk("clr_k1", 32'(k), 32'hF);
      chk("clr_ready1", 32'(in_ready), 32'd0);
      step();
      chk("clr_k2", 32'(k), 32'd0);
      chk("clr_ready2", 32'(in_ready), 32'd0);
      step();
      chk("clr_ready3", 32'(in_ready), 32'd1);
      chk("clr_done3", 32'(done), 32'd0);
      chk("clr_mismatch3", 32'(mismatch), 32'd0);
      chk("clr_err3", 32'(err_count), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] tg[3];
      logic [3:0] ej[3];
      logic [3:0] ek[3];
      int         idx;
      int         eerr;

      rst = 1'b0;
      in_valid = 1'b0;
      in_target = 4'h0;
      repeat (3) step();
      rst = 1'b1;
      check_clr();
      chk("flops_cleared", 32'(flops), 32'd0);

      xfer(4'b1010, 4'b1010, 4'b0000, 1'b0, 8'd0);
      xfer(4'b0110, 4'b0100, 4'b1000, 1'b0, 8'd0);
      xfer(4'b1010, 4'b1000, 4'b0100, 1'b0, 8'd0);
      xfer(4'b0001, 4'b0001, 4'b1010, 1'b0, 8'd0);
      ign_k0 = 1'b1;
      xfer(4'b0000, 4'b0000, 4'b0001, 1'b1, 8'd1);
      xfer(4'b0000, 4'b0000, 4'b0001, 1'b1, 8'd2);
      ign_k0 = 1'b0;
      xfer(4'b0000, 4'b0000, 4'b0001, 1'b0, 8'd2);

      // Back-to-back with in_valid held high
      tg[0] = 4'b0011; ej[0] = 4'b0011; ek[0] = 4'b0000;
      tg[1] = 4'b1100; ej[1] = 4'b1100; ek[1] = 4'b0011;
      tg[2] = 4'b0000; ej[2] = 4'b0000; ek[2] = 4'b1100;
      idx = 0;
      in_valid  = 1'b1;
      in_target = tg[0];
      for (int c = 0; c < 9; c++) begin
         chk("b2b_ready", 32'(in_ready), (c % 3 == 0) ? 32'd1 : 32'd0);
         if (in_ready && in_valid) begin
            exp_q.push_back({1'b1, 1'b0, 8'd2});
            idx++;
         end
         step();
         if (c % 3 == 0 && idx > 0) begin
            chk("b2b_j", 32'(j), 32'(ej[idx-1]));
            chk("b2b_k", 32'(k), 32'(ek[idx-1]));
         end
         if (idx < 3) in_target = tg[idx];
         else         in_valid  = 1'b0;
      end
      chk("b2b_accepts", 32'(idx), 32'd3);
      chk("b2b_ready_after", 32'(in_ready), 32'd1);

      // Reset while waiting for feedback: no done, clear replayed
      in_valid  = 1'b1;
      in_target = 4'b1111;
      step();
      in_valid = 1'b0;
      chk("abort_j_drive", 32'(j), 32'hF);
      step();
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_clr();

      // Saturation of the error counter
      xfer(4'b0001, 4'b0001, 4'b0000, 1'b0, 8'd0);
      ign_k0 = 1'b1;
      eerr = 0;
      for (int i = 0; i < 300; i++) begin
         eerr = (eerr < 255) ? eerr + 1 : 255;
         xfer(4'b0000, 4'b0000, 4'b0001, 1'b1, 8'(eerr));
      end
      ign_k0 = 1'b0;
      step();
      chk("err_saturated", 32'(err_count), 32'd255);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
